// File: rtl/mult_pkg.sv
// Shared defaults and FSM state type for the multiplier datapath blocks.
package mult_pkg;

    localparam int PRODUCT_WIDTH = 8;
    localparam int ACC_WIDTH     = 12;
    localparam int ACC_COUNT     = 16;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

endpackage

// File: rtl/sat_adder.sv
// Accumulator adder: clamps to all-ones on carry-out when ACC_SATURATE_EN is
// defined, otherwise wraps modulo 2^Width with overflow tied low.
module sat_adder #(
    parameter int Width = 12
) (
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic [Width-1:0] sum,
    output logic             overflow
);

`ifdef ACC_SATURATE_EN
    logic [Width:0] full;

    // Once the accumulator sits at all-ones, any nonzero addend carries out again,
    // so the clamp stays sticky without needing the previous overflow state.
    assign full     = {1'b0, a} + {1'b0, b};
    assign sum      = full[Width] ? {Width{1'b1}} : full[Width-1:0];
    assign overflow = full[Width];
`else
    assign sum      = a + b;
    assign overflow = 1'b0;
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums Acc_Count products per frame and holds the result until consumed.
// Saturation versus wrap is selected in sat_adder by ACC_SATURATE_EN.
module product_accumulator
    import mult_pkg::*;
#(
    parameter int Product_Width = PRODUCT_WIDTH,
    parameter int Acc_Width     = ACC_WIDTH,
    parameter int Acc_Count     = ACC_COUNT
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [Product_Width-1:0]         Product,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             acc_clear,
    output logic [Acc_Width-1:0]             out_sum,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_overflow,
    output logic [$clog2(Acc_Count+1)-1:0]   sample_cnt
);

    localparam int CntWidth = $clog2(Acc_Count + 1);

    acc_state_t          state;
    logic [Acc_Width-1:0] acc;
    logic                 ovf_seen;
    logic [Acc_Width-1:0] add_sum;
    logic                 add_ovf;
    logic [CntWidth-1:0]  cnt_inc;

    sat_adder #(
        .Width(Acc_Width)
    ) u_sat_adder (
        .a        (acc),
        .b        (Acc_Width'(Product)),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    assign in_ready = (state == ACCUM);
    assign cnt_inc  = sample_cnt + CntWidth'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ACCUM;
            acc          <= '0;
            ovf_seen     <= 1'b0;
            sample_cnt   <= '0;
            out_sum      <= '0;
            out_valid    <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    // A clear takes priority and drops any product offered alongside it.
                    if (acc_clear) begin
                        acc        <= '0;
                        ovf_seen   <= 1'b0;
                        sample_cnt <= '0;
                    end else if (in_valid) begin
                        if (cnt_inc == CntWidth'(Acc_Count)) begin
                            out_sum      <= add_sum;
                            out_overflow <= ovf_seen | add_ovf;
                            out_valid    <= 1'b1;
                            acc          <= '0;
                            ovf_seen     <= 1'b0;
                            sample_cnt   <= '0;
                            state        <= HOLD;
                        end else begin
                            acc        <= add_sum;
                            ovf_seen   <= ovf_seen | add_ovf;
                            sample_cnt <= cnt_inc;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
